// File: rtl/ariane_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ariane_axi
//  Description : AXI4 channel and bundle types for the core memory port.
//                The req_t bundle carries everything a master drives and
//                resp_t everything a slave drives.
//  Revision    : 1.0 - initial release
// ============================================================================
package ariane_axi;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      logic [5:0]  atop;
      logic [0:0]  user;
   } aw_chan_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
      logic [0:0]  user;
   } w_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [1:0]  resp;
      logic [0:0]  user;
   } b_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      logic [0:0]  user;
   } ar_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [0:0]  user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic     aw_ready;
      logic     ar_ready;
      logic     w_ready;
      logic     b_valid;
      b_chan_t  b;
      logic     r_valid;
      r_chan_t  r;
   } resp_t;

endpackage
`default_nettype wire

// File: rtl/axi_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : axi_mem_arb_pkg
//  Description : State encodings and helpers shared by the memory-port
//                arbiter and its round-robin sub-arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_mem_arb_pkg;

   localparam int unsigned NUM_MASTERS = 2;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_XFER = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   // Watchdog counters stop at all-ones instead of wrapping back through TIMEOUT.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-requester arbiter. With fixed_prio set, requester 0
//                wins contention; otherwise the pointer favours the side
//                that was not granted last. Pointer resets to requester 0.
//  Ports       : clk, rst_n (sync, active-low), req[1:0], fixed_prio,
//                update (a grant is being taken this cycle), gnt_idx
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       fixed_prio,
   input  logic       update,
   output logic       gnt_idx
);

   logic ptr;

   always_comb begin
      gnt_idx = 1'b0;
      if (req == 2'b11) begin
         gnt_idx = fixed_prio ? 1'b0 : ptr;
      end else if (req[1]) begin
         gnt_idx = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (update) begin
         ptr <= ~gnt_idx;
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_arbiter
//  Description : Shares one AXI4 memory port between two masters. Reads and
//                writes are arbitrated independently, one transaction in
//                flight per direction, responses routed to the owner.
//  Ports       : clk_i, rst_ni (sync, active-low)
//                m_req_i[2] / m_resp_o[2]  master-side AXI bundles
//                s_req_o / s_resp_i        shared memory-port bundle
//                rd_owner_o, rd_busy_o, wr_owner_o, wr_busy_o  status
//                timeout_o                 sticky watchdog flag
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_arbiter
   import axi_mem_arb_pkg::*;
#(
   parameter bit          FIXED_PRIO = 1'b0,
   parameter int unsigned TIMEOUT    = 32'd0
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  ariane_axi::req_t  [NUM_MASTERS-1:0] m_req_i,
   output ariane_axi::resp_t [NUM_MASTERS-1:0] m_resp_o,
   output ariane_axi::req_t                     s_req_o,
   input  ariane_axi::resp_t                    s_resp_i,
   output logic                                rd_owner_o,
   output logic                                rd_busy_o,
   output logic                                wr_owner_o,
   output logic                                wr_busy_o,
   output logic                                timeout_o
);

   rd_state_e   rd_state, rd_state_nxt;
   wr_state_e   wr_state, wr_state_nxt;
   logic        rd_owner, wr_owner;
   logic        rd_gnt_idx, wr_gnt_idx;
   logic        rd_grant, wr_grant;
   logic        aw_done, w_done, aw_done_nxt, w_done_nxt;
   logic        rd_ar_hs, rd_r_hs, wr_aw_hs, wr_w_hs, wr_b_hs;
   logic [31:0] rd_cnt, wr_cnt, rd_cnt_nxt, wr_cnt_nxt;
   logic        timeout;

   // Grants are only taken from IDLE; the winner is latched and forwarding
   // starts the following cycle.
   assign rd_grant = (rd_state == R_IDLE) && (m_req_i[0].ar_valid || m_req_i[1].ar_valid);
   assign wr_grant = (wr_state == W_IDLE) && (m_req_i[0].aw_valid || m_req_i[1].aw_valid);

   rr_arb2 u_rd_arb (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .req        ({m_req_i[1].ar_valid, m_req_i[0].ar_valid}),
      .fixed_prio (FIXED_PRIO),
      .update     (rd_grant),
      .gnt_idx    (rd_gnt_idx)
   );

   rr_arb2 u_wr_arb (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .req        ({m_req_i[1].aw_valid, m_req_i[0].aw_valid}),
      .fixed_prio (FIXED_PRIO),
      .update     (wr_grant),
      .gnt_idx    (wr_gnt_idx)
   );

   // Read FSM next state
   always_comb begin
      rd_state_nxt = rd_state;
      rd_ar_hs     = 1'b0;
      rd_r_hs      = 1'b0;
      case (rd_state)
         R_IDLE: if (rd_grant) rd_state_nxt = R_ADDR;
         R_ADDR: begin
            rd_ar_hs = m_req_i[rd_owner].ar_valid && s_resp_i.ar_ready;
            if (rd_ar_hs) rd_state_nxt = R_DATA;
         end
         R_DATA: begin
            rd_r_hs = s_resp_i.r_valid && m_req_i[rd_owner].r_ready;
            if (rd_r_hs && s_resp_i.r.last) rd_state_nxt = R_IDLE;
         end
         default: rd_state_nxt = R_IDLE;
      endcase
   end

   // Write FSM next state. AW and the last W beat are tracked separately so
   // either order (or the same cycle) completes the transfer phase.
   always_comb begin
      wr_state_nxt = wr_state;
      wr_aw_hs     = (wr_state == W_XFER) && !aw_done &&
                     m_req_i[wr_owner].aw_valid && s_resp_i.aw_ready;
      wr_w_hs      = (wr_state == W_XFER) && !w_done &&
                     m_req_i[wr_owner].w_valid && s_resp_i.w_ready;
      wr_b_hs      = (wr_state == W_RESP) && s_resp_i.b_valid && m_req_i[wr_owner].b_ready;
      aw_done_nxt  = aw_done || wr_aw_hs;
      w_done_nxt   = w_done || (wr_w_hs && m_req_i[wr_owner].w.last);
      case (wr_state)
         W_IDLE:  if (wr_grant) wr_state_nxt = W_XFER;
         W_XFER:  if (aw_done_nxt && w_done_nxt) wr_state_nxt = W_RESP;
         W_RESP:  if (wr_b_hs) wr_state_nxt = W_IDLE;
         default: wr_state_nxt = W_IDLE;
      endcase
   end

   // Channel muxing. Payloads always follow the owner; only valids/readys
   // are qualified by state and ownership.
   always_comb begin
      s_req_o          = '0;
      m_resp_o         = '0;
      s_req_o.ar       = m_req_i[rd_owner].ar;
      s_req_o.aw       = m_req_i[wr_owner].aw;
      s_req_o.w        = m_req_i[wr_owner].w;
      s_req_o.ar_valid = (rd_state == R_ADDR) && m_req_i[rd_owner].ar_valid;
      s_req_o.r_ready  = (rd_state == R_DATA) && m_req_i[rd_owner].r_ready;
      s_req_o.aw_valid = (wr_state == W_XFER) && !aw_done && m_req_i[wr_owner].aw_valid;
      s_req_o.w_valid  = (wr_state == W_XFER) && !w_done && m_req_i[wr_owner].w_valid;
      s_req_o.b_ready  = (wr_state == W_RESP) && m_req_i[wr_owner].b_ready;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         m_resp_o[k].r        = s_resp_i.r;
         m_resp_o[k].b        = s_resp_i.b;
         m_resp_o[k].ar_ready = (rd_state == R_ADDR) && (rd_owner == 1'(k)) && s_resp_i.ar_ready;
         m_resp_o[k].r_valid  = (rd_state == R_DATA) && (rd_owner == 1'(k)) && s_resp_i.r_valid;
         m_resp_o[k].aw_ready = (wr_state == W_XFER) && !aw_done && (wr_owner == 1'(k)) &&
                                s_resp_i.aw_ready;
         m_resp_o[k].w_ready  = (wr_state == W_XFER) && !w_done && (wr_owner == 1'(k)) &&
                                s_resp_i.w_ready;
         m_resp_o[k].b_valid  = (wr_state == W_RESP) && (wr_owner == 1'(k)) && s_resp_i.b_valid;
      end
   end

   // Watchdog: count busy cycles with no progress on the active channel(s).
   assign rd_cnt_nxt = ((rd_state == R_IDLE) || rd_ar_hs || rd_r_hs) ? 32'd0 : sat_inc(rd_cnt);
   assign wr_cnt_nxt = ((wr_state == W_IDLE) || wr_aw_hs || wr_w_hs || wr_b_hs) ?
                       32'd0 : sat_inc(wr_cnt);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_state <= R_IDLE;
         wr_state <= W_IDLE;
         rd_owner <= 1'b0;
         wr_owner <= 1'b0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         rd_cnt   <= 32'd0;
         wr_cnt   <= 32'd0;
         timeout  <= 1'b0;
      end else begin
         rd_state <= rd_state_nxt;
         wr_state <= wr_state_nxt;
         if (rd_grant) rd_owner <= rd_gnt_idx;
         if (wr_grant) wr_owner <= wr_gnt_idx;
         aw_done  <= (wr_state_nxt == W_XFER) && aw_done_nxt;
         w_done   <= (wr_state_nxt == W_XFER) && w_done_nxt;
         rd_cnt   <= rd_cnt_nxt;
         wr_cnt   <= wr_cnt_nxt;
         if ((TIMEOUT != 32'd0) && ((rd_cnt_nxt == TIMEOUT) || (wr_cnt_nxt == TIMEOUT))) begin
            timeout <= 1'b1;
         end
      end
   end

   assign rd_owner_o = rd_owner;
   assign wr_owner_o = wr_owner;
   assign rd_busy_o  = (rd_state != R_IDLE);
   assign wr_busy_o  = (wr_state != W_IDLE);
   assign timeout_o  = timeout;

endmodule
`default_nettype wire
